// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_unit and if_id_latch.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FS_RUN,
        FS_HALT
    } fetch_state_t;

    parameter word_t HALT_INSTR = 32'hFFFF_FFFF;
    parameter word_t NOP_INSTR  = 32'h0;

endpackage

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline latch holding {instr, npc, valid}.
// Priority: bubble > load > hold.
module if_id_latch
    import fetch_unit_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  bubble,
    input  word_t instr_d,
    input  word_t npc_d,
    output word_t instr,
    output word_t npc,
    output logic  valid
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            npc   <= npc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request, halt FSM and IF/ID latch.
// Define FETCH_PERF_EN to enable the saturating fetch_count performance counter.
//
// state   | meaning
// FS_RUN  | fetching; imemREN asserted
// FS_HALT | halt word latched; fetch frozen until redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t PC_INIT   = 32'h0000_0000,
    parameter word_t HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid,
    output logic  halted,
    output word_t fetch_count
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next, pc_plus4;
    logic         advance, is_halt;
    logic         latch_load, latch_bubble;

    assign pc_plus4 = pc + 32'd4;
    assign advance  = (state == FS_RUN) && ihit && !stall && !redirect;
    assign is_halt  = (imemload == HALT_WORD);
    assign imemREN  = (state == FS_RUN);
    assign imemaddr = pc;
    assign halted   = (state == FS_HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FS_RUN;
            pc    <= PC_INIT;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        latch_load   = 1'b0;
        latch_bubble = 1'b0;
        if (redirect) begin
            state_next   = FS_RUN;
            pc_next      = {redirect_pc[31:2], 2'b00};
            latch_bubble = 1'b1;
        end else if (stall) begin
            latch_bubble = flush;
        end else if (advance) begin
            latch_load   = 1'b1;
            latch_bubble = flush;
            if (is_halt) begin
                state_next = FS_HALT;
            end else begin
                pc_next = pc_plus4;
            end
        end else begin
            // idle or halted without stall: never let decode see a stale instruction twice
            latch_bubble = 1'b1;
        end
    end

    if_id_latch u_if_id (
        .CLK     (CLK),
        .nRST    (nRST),
        .load    (latch_load),
        .bubble  (latch_bubble),
        .instr_d (imemload),
        .npc_d   (pc_plus4),
        .instr   (ifid_instr),
        .npc     (ifid_npc),
        .valid   (ifid_valid)
    );

`ifdef FETCH_PERF_EN
    word_t count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (advance && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  ihit, stall, flush, redirect;
    word_t imemload, redirect_pc;
    logic  imemREN, ifid_valid, halted;
    word_t imemaddr, ifid_instr, ifid_npc, fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input word_t ins, input word_t npc, input logic v);
        chk({tag, ".instr"}, ifid_instr, ins);
        chk({tag, ".npc"}, ifid_npc, npc);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".addr"}, imemaddr, 32'h0);
        chk({tag, ".ren"}, {31'd0, imemREN}, 32'd1);
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".count"}, fetch_count, 32'd0);
        chk_ifid(tag, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        word_t exp_cnt;
        nRST = 1'b0; ihit = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        imemload = '0; redirect_pc = '0;
        #12;
        chk_reset_state("reset");
        nRST = 1'b1;
        tick();
        chk("idle_after_reset.addr", imemaddr, 32'h0);

        // straight-line fetch
        ihit = 1'b1; imemload = 32'h2001_0005;
        tick();
        chk("fetch0.addr", imemaddr, 32'h4);
        chk_ifid("fetch0", 32'h2001_0005, 32'h4, 1'b1);
        imemload = 32'h2002_0007;
        tick();
        chk("fetch1.addr", imemaddr, 32'h8);
        chk_ifid("fetch1", 32'h2002_0007, 32'h8, 1'b1);
        imemload = 32'h0;
        tick();
        tick();
        chk("fetch3.addr", imemaddr, 32'h10);

        // no ihit: pc holds, bubbles
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("miss.addr", imemaddr, 32'h10);
            chk("miss.valid", {31'd0, ifid_valid}, 32'd0);
        end

        ihit = 1'b1;
        imemload = 32'h11; tick();
        imemload = 32'h22; tick();
        imemload = 32'h33; tick();
        imemload = 32'hAA; tick();
        chk("to20.addr", imemaddr, 32'h20);
        chk_ifid("to20", 32'hAA, 32'h20, 1'b1);

        // stall holds pc and IF/ID
        stall = 1'b1; imemload = 32'h123;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall.addr", imemaddr, 32'h20);
            chk_ifid("stall", 32'hAA, 32'h20, 1'b1);
        end
        flush = 1'b1;
        tick();
        chk("stallflush.addr", imemaddr, 32'h20);
        chk_ifid("stallflush", 32'h0, 32'h0, 1'b0);
        flush = 1'b0;

        // redirect beats stall and ihit, low bits cleared
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk("redir.addr", imemaddr, 32'h100);
        chk("redir.valid", {31'd0, ifid_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0; imemload = 32'h3;
        tick();
        chk("resume.addr", imemaddr, 32'h104);
        chk_ifid("resume", 32'h3, 32'h104, 1'b1);

        // halt
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; imemload = 32'hFFFF_FFFF;
        tick();
        chk("halt.addr", imemaddr, 32'h40);
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.ren", {31'd0, imemREN}, 32'd0);
        chk_ifid("halt", 32'hFFFF_FFFF, 32'h44, 1'b1);
        imemload = 32'h55;
        tick();
        chk("halted.addr", imemaddr, 32'h40);
        chk("halted.halted", {31'd0, halted}, 32'd1);
        chk("halted.valid", {31'd0, ifid_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        chk("unhalt.addr", imemaddr, 32'h80);
        chk("unhalt.halted", {31'd0, halted}, 32'd0);
        chk("unhalt.ren", {31'd0, imemREN}, 32'd1);

        // wrap at top of address space
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("top.addr", imemaddr, 32'hFFFF_FFFC);
        redirect = 1'b0; imemload = 32'h5;
        tick();
        chk("wrap.addr", imemaddr, 32'h0);
        chk_ifid("wrap", 32'h5, 32'h0, 1'b1);

        // flush with advance: pc moves, IF/ID bubbles
        flush = 1'b1; imemload = 32'h77;
        tick();
        chk("advflush.addr", imemaddr, 32'h4);
        chk("advflush.valid", {31'd0, ifid_valid}, 32'd0);
        flush = 1'b0;

`ifdef FETCH_PERF_EN
        exp_cnt = 32'd12;
`else
        exp_cnt = 32'd0;
`endif
        chk("count", fetch_count, exp_cnt);

        // async reset mid-stall
        imemload = 32'h99;
        tick();
        stall = 1'b1;
        tick();
        #2 nRST = 1'b0;
        #1;
        chk_reset_state("async_rst");
        #3 nRST = 1'b1;
        stall = 1'b0; ihit = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
